// File: rtl/lfsr_pkg.sv
// Shared definitions for the XNOR-feedback LFSR generator/checker family.
// Holds the checker state type, the default register geometry and the
// feedback function used by generator models.
package lfsr_pkg;

   typedef enum logic {
      SEARCH = 1'b0,
      LOCKED = 1'b1
   } state_e;

   localparam int LFSR_N   = 10;
   localparam int LFSR_TAP = 7;

   // XNOR feedback bit for a register where bit k-1 holds stage k
   function automatic logic lfsr_next(input logic [LFSR_N-1:0] s);
      return ~(s[LFSR_TAP-1] ^ s[LFSR_N-1]);
   endfunction

endpackage

// File: rtl/lfsr_chk_if.sv
// Stream/status bundle between a bit source (master) and lfsr_chk (slave).
interface lfsr_chk_if #(
   parameter int CNT_W = 16
);
   logic             din;
   logic             din_valid;
   logic             clear_cnt;
   logic             locked;
   logic             bit_err;
   logic [CNT_W-1:0] err_count;

   modport master (
      output din, din_valid, clear_cnt,
      input  locked, bit_err, err_count
   );

   modport slave (
      input  din, din_valid, clear_cnt,
      output locked, bit_err, err_count
   );
endinterface

// File: rtl/lfsr_chk_win.sv
// Loss-of-lock window tracker: counts accepted bits in fixed blocks of
// WINDOW bits, tallies errors per block and raises loss_o on the accepted
// bit whose error brings the tally to LOSS_ERRS. An error on the last bit
// of a block (the wrap bit) is charged to the block that starts there.
module lfsr_chk_win #(
   parameter int WINDOW    = 128,
   parameter int LOSS_ERRS = 4
) (
   input  logic clk,
   input  logic reset,
   input  logic clr_i,
   input  logic acc_i,
   input  logic err_i,
   output logic loss_o
);

   localparam int WW = (WINDOW > 1) ? $clog2(WINDOW) : 1;
   localparam int EW = $clog2(LOSS_ERRS + 1);
   localparam logic [WW-1:0] WIN_LAST  = WW'(WINDOW - 1);
   localparam logic [EW-1:0] ERR_LIMIT = EW'(LOSS_ERRS);

   logic [WW-1:0] win_cnt_q;
   logic [EW-1:0] win_err_q;
   logic [EW-1:0] win_err_d;
   logic          wrap;

   assign wrap = (win_cnt_q == WIN_LAST);

   // Error tally after this bit: restart on the wrap bit, then add this bit's error
   always_comb begin
      win_err_d = wrap ? '0 : win_err_q;
      if (err_i) begin
         win_err_d = win_err_d + 1'b1;
      end
   end

   assign loss_o = acc_i && err_i && (win_err_d == ERR_LIMIT);

   // Block position and error tally, held at zero while not locked
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         win_cnt_q <= '0;
         win_err_q <= '0;
      end else if (clr_i) begin
         win_cnt_q <= '0;
         win_err_q <= '0;
      end else if (acc_i) begin
         win_cnt_q <= wrap ? '0 : win_cnt_q + 1'b1;
         win_err_q <= win_err_d;
      end
   end

endmodule

// File: rtl/lfsr_chk.sv
// Receive-side checker for the XNOR LFSR bit stream. Loads N bits, then
// needs LOCK_MATCH consecutive correct predictions to lock; once locked it
// flywheels on its own prediction and reports mismatches.
// Optional macro LFSR_CHK_ERR_CNT_EN: when defined, err_count is a
// saturating counter with clear_cnt; otherwise err_count is tied to 0.
module lfsr_chk
   import lfsr_pkg::*;
#(
   parameter int N          = LFSR_N,
   parameter int TAP        = LFSR_TAP,
   parameter int LOCK_MATCH = 16,
   parameter int WINDOW     = 128,
   parameter int LOSS_ERRS  = 4,
   parameter int CNT_W      = 16
) (
   input  logic       clk,
   input  logic       reset,
   lfsr_chk_if.slave  bus
);

   localparam int LW = $clog2(N + 1);
   localparam int MW = $clog2(LOCK_MATCH + 1);
   localparam logic [LW-1:0] LOAD_FULL  = LW'(N);
   localparam logic [MW-1:0] MATCH_DONE = MW'(LOCK_MATCH);

   state_e        state_q;
   logic [N-1:0]  s_q;          // s_q[k-1] is stage k; stage 1 takes the new bit
   logic [LW-1:0] load_cnt_q;
   logic [MW-1:0] match_cnt_q;
   logic          locked_q;
   logic          bit_err_q;

   logic acc;
   logic exp_bit;
   logic mismatch;
   logic loss;

   assign acc      = bus.din_valid;
   assign exp_bit  = ~(s_q[TAP-1] ^ s_q[N-1]);
   assign mismatch = bus.din ^ exp_bit;

   lfsr_chk_win #(
      .WINDOW    (WINDOW),
      .LOSS_ERRS (LOSS_ERRS)
   ) u_win (
      .clk    (clk),
      .reset  (reset),
      .clr_i  (state_q == SEARCH),
      .acc_i  (acc && (state_q == LOCKED)),
      .err_i  (mismatch),
      .loss_o (loss)
   );

   // Acquisition / flywheel state machine with registered lock and error pulse
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= SEARCH;
         s_q         <= '0;
         load_cnt_q  <= '0;
         match_cnt_q <= '0;
         locked_q    <= 1'b0;
         bit_err_q   <= 1'b0;
      end else begin
         bit_err_q <= 1'b0;
         if (acc) begin
            case (state_q)
               SEARCH: begin
                  s_q <= {s_q[N-2:0], bus.din};
                  if (load_cnt_q != LOAD_FULL) begin
                     load_cnt_q <= load_cnt_q + 1'b1;
                  end else if (!mismatch && (s_q != '1)) begin
                     // all-ones is the XNOR lockup state and never counts
                     if (match_cnt_q + 1'b1 == MATCH_DONE) begin
                        state_q     <= LOCKED;
                        locked_q    <= 1'b1;
                        match_cnt_q <= '0;
                     end else begin
                        match_cnt_q <= match_cnt_q + 1'b1;
                     end
                  end else begin
                     match_cnt_q <= '0;
                  end
               end
               LOCKED: begin
                  // flywheel: line errors never enter the register
                  s_q       <= {s_q[N-2:0], exp_bit};
                  bit_err_q <= mismatch;
                  if (loss) begin
                     state_q     <= SEARCH;
                     locked_q    <= 1'b0;
                     load_cnt_q  <= '0;
                     match_cnt_q <= '0;
                  end
               end
               default: state_q <= SEARCH;
            endcase
         end
      end
   end

   assign bus.locked  = locked_q;
   assign bus.bit_err = bit_err_q;

`ifdef LFSR_CHK_ERR_CNT_EN
   localparam logic [CNT_W-1:0] CNT_MAX = '1;
   logic [CNT_W-1:0] err_cnt_q;

   // Saturating error count; clear beats a same-cycle increment
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         err_cnt_q <= '0;
      end else if (bus.clear_cnt) begin
         err_cnt_q <= '0;
      end else if (acc && (state_q == LOCKED) && mismatch && (err_cnt_q != CNT_MAX)) begin
         err_cnt_q <= err_cnt_q + 1'b1;
      end
   end

   assign bus.err_count = err_cnt_q;
`else
   logic unused_clear_cnt;
   assign unused_clear_cnt = bus.clear_cnt;
   assign bus.err_count    = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_lfsr_chk.sv
// Bench for lfsr_chk: two instances (default, and CNT_W=4 / LOSS_ERRS=32)
// share one stimulus stream and are checked against a bit-history model.
module tb_lfsr_chk;
   import lfsr_pkg::*;

   localparam int N          = LFSR_N;
   localparam int TAP        = LFSR_TAP;
   localparam int LOCK_MATCH = 16;
   localparam int WINDOW     = 128;
`ifdef LFSR_CHK_ERR_CNT_EN
   localparam bit CNT_EN = 1'b1;
`else
   localparam bit CNT_EN = 1'b0;
`endif

   logic clk = 1'b0;
   logic reset = 1'b1;
   logic din = 1'b0, din_valid = 1'b0, clear_cnt = 1'b0;
   always #5 clk = ~clk;

   lfsr_chk_if #(.CNT_W(16)) bus0 ();
   lfsr_chk_if #(.CNT_W(4))  bus1 ();
   assign bus0.din = din;  assign bus0.din_valid = din_valid;  assign bus0.clear_cnt = clear_cnt;
   assign bus1.din = din;  assign bus1.din_valid = din_valid;  assign bus1.clear_cnt = clear_cnt;

   lfsr_chk dut0 (.clk(clk), .reset(reset), .bus(bus0));
   lfsr_chk #(.LOSS_ERRS(32), .CNT_W(4)) dut1 (.clk(clk), .reset(reset), .bus(bus1));

   logic [17:0] obs0;
   logic [5:0]  obs1;
   assign obs0 = {bus0.locked, bus0.bit_err, bus0.err_count};
   assign obs1 = {bus1.locked, bus1.bit_err, bus1.err_count};

   int tests = 0;
   int fails = 0;

   // ---------------- generator and reference model ----------------
   logic [N-1:0] g = '0;
   bit hist0[$];
   bit hist1[$];
   bit m_locked[2], m_berr[2];
   int m_cnt[2], m_run[2], m_j[2], m_curw[2], m_werr[2];

   task automatic gen(output bit b);
      b = lfsr_next(g);
      g = {g[N-2:0], b};
   endtask

   task automatic model_reset();
      for (int i = 0; i < 2; i++) begin
         m_locked[i] = 0; m_berr[i] = 0; m_cnt[i] = 0; m_run[i] = 0;
         m_j[i] = 0; m_curw[i] = 0; m_werr[i] = 0;
      end
      hist0.delete();
      hist1.delete();
   endtask

   // hist holds the checker's view of recent bits; last element = newest
   task automatic model_step(input bit v, input bit b, input bit clr);
      for (int i = 0; i < 2; i++) begin
         bit h[$];
         int len, lim, cmax, w;
         bit p, ones, e;
         lim  = (i == 0) ? 4 : 32;
         cmax = (i == 0) ? 65535 : 15;
         if (i == 0) h = hist0; else h = hist1;
         m_berr[i] = 0;
         if (v) begin
            len = h.size();
            p = 0; ones = 1; e = 0;
            if (len >= N) begin
               p = !(h[len-TAP] ^ h[len-N]);
               for (int k = len - N; k < len; k++) if (!h[k]) ones = 0;
            end
            if (!m_locked[i]) begin
               if (len >= N) m_run[i] = (b == p && !ones) ? m_run[i] + 1 : 0;
               h.push_back(b);
               if (m_run[i] == LOCK_MATCH) begin
                  m_locked[i] = 1; m_run[i] = 0;
                  m_j[i] = 0; m_curw[i] = 0; m_werr[i] = 0;
               end
            end else begin
               e = (b != p);
               h.push_back(p);
               m_berr[i] = e;
               if (e && !clr && m_cnt[i] < cmax) m_cnt[i]++;
               w = (m_j[i] + 1) / WINDOW;
               if (w != m_curw[i]) begin m_curw[i] = w; m_werr[i] = 0; end
               if (e) m_werr[i]++;
               m_j[i]++;
               if (m_werr[i] == lim) begin
                  m_locked[i] = 0; m_run[i] = 0;
                  h.delete();
               end
            end
            while (h.size() > N) void'(h.pop_front());
         end
         if (clr) m_cnt[i] = 0;
         if (i == 0) hist0 = h; else hist1 = h;
      end
   endtask

   function automatic logic [17:0] exp0();
      return {m_locked[0], m_berr[0], CNT_EN ? 16'(m_cnt[0]) : 16'd0};
   endfunction

   function automatic logic [5:0] exp1();
      return {m_locked[1], m_berr[1], CNT_EN ? 4'(m_cnt[1]) : 4'd0};
   endfunction

   task automatic cycle(input bit v, input bit b, input bit clr);
      din = b; din_valid = v; clear_cnt = clr;
      @(posedge clk); #1;
      model_step(v, b, clr);
   endtask

   task automatic do_reset();
      din_valid = 0; clear_cnt = 0; reset = 1;
      @(posedge clk); #1;
      #2 reset = 0;
      model_reset();
      g = '0;
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      reset = 1;
      for (int k = 0; k < 3; k++) begin
         din = k[0]; din_valid = 1; clear_cnt = 0;
         @(posedge clk); #1;
         tests++; if (obs0 !== 18'd0) begin fails++; $display("FAIL reset dut0 cyc %0d: got %h want 0", k, obs0); end
         tests++; if (obs1 !== 6'd0)  begin fails++; $display("FAIL reset dut1 cyc %0d: got %h want 0", k, obs1); end
      end
      do_reset();
      $display("[TB] reset: outputs checked under reset");
   endtask

   task automatic test_clean_lock();
      int lock0 = 0, lock1 = 0, berrs = 0;
      bit b;
      for (int k = 1; k <= 1000; k++) begin
         gen(b); cycle(1, b, 0);
         tests++; if (obs0 !== exp0()) begin fails++; $display("FAIL clean_lock dut0 bit %0d: got %h want %h", k, obs0, exp0()); end
         tests++; if (obs1 !== exp1()) begin fails++; $display("FAIL clean_lock dut1 bit %0d: got %h want %h", k, obs1, exp1()); end
         if (bus0.locked && lock0 == 0) lock0 = k;
         if (bus1.locked && lock1 == 0) lock1 = k;
         if (bus0.bit_err) berrs++;
      end
      tests++; if (lock0 !== N + LOCK_MATCH) begin fails++; $display("FAIL lock_latency dut0: got %0d want %0d", lock0, N + LOCK_MATCH); end
      tests++; if (lock1 !== N + LOCK_MATCH) begin fails++; $display("FAIL lock_latency dut1: got %0d want %0d", lock1, N + LOCK_MATCH); end
      tests++; if (berrs !== 0) begin fails++; $display("FAIL clean_bit_err: got %0d pulses want 0", berrs); end
      $display("[TB] clean_lock: locked after %0d bits", lock0);
   endtask

   task automatic test_single_error();
      int late = 0;
      bit b;
      gen(b); cycle(1, b, 1);
      for (int k = 1; k <= 250; k++) begin
         gen(b); cycle(1, (k == 200) ? ~b : b, 0);
         tests++; if (obs0 !== exp0()) begin fails++; $display("FAIL single_err dut0 bit %0d: got %h want %h", k, obs0, exp0()); end
         if (k == 200) begin
            tests++; if (bus0.bit_err !== 1'b1) begin fails++; $display("FAIL single_err pulse: got %b want 1", bus0.bit_err); end
            tests++; if (bus0.err_count !== (CNT_EN ? 16'd1 : 16'd0)) begin fails++; $display("FAIL single_err count: got %0d want %0d", bus0.err_count, CNT_EN); end
         end
         if (k > 200 && bus0.bit_err) late++;
      end
      tests++; if (late !== 0 || bus0.locked !== 1'b1) begin fails++; $display("FAIL single_err flywheel: late=%0d locked=%b want 0/1", late, bus0.locked); end
      $display("[TB] single_error: injected at bit 200");
   endtask

   task automatic test_loss();
      int n = 0, relock = 0;
      bit b;
      gen(b); cycle(1, b, 1);
      while (m_j[0] % WINDOW != 10 && n < 300) begin gen(b); cycle(1, b, 0); n++; end
      for (int k = 0; k < 16; k++) begin
         gen(b); cycle(1, (k % 5 == 0) ? ~b : b, 0);
         tests++; if (obs0 !== exp0()) begin fails++; $display("FAIL loss dut0 step %0d: got %h want %h", k, obs0, exp0()); end
         if (k == 15) begin
            tests++; if (bus0.locked !== 1'b0) begin fails++; $display("FAIL loss_locked: got %b want 0", bus0.locked); end
            tests++; if (bus0.err_count !== (CNT_EN ? 16'd4 : 16'd0)) begin fails++; $display("FAIL loss_count: got %0d want %0d", bus0.err_count, CNT_EN ? 4 : 0); end
         end
      end
      for (int k = 1; k <= 200 && relock == 0; k++) begin
         gen(b); cycle(1, b, 0);
         tests++; if (obs0 !== exp0()) begin fails++; $display("FAIL relock dut0 bit %0d: got %h want %h", k, obs0, exp0()); end
         if (bus0.locked) relock = k;
      end
      tests++; if (relock !== N + LOCK_MATCH) begin fails++; $display("FAIL relock_latency: got %0d want %0d", relock, N + LOCK_MATCH); end
      $display("[TB] loss: relocked after %0d bits", relock);
   endtask

   task automatic test_window_boundary();
      int n = 0;
      bit b;
      gen(b); cycle(1, b, 1);
      while (m_j[0] % WINDOW != WINDOW - 4 && n < 300) begin gen(b); cycle(1, b, 0); n++; end
      for (int k = 0; k < 12; k++) begin
         gen(b); cycle(1, (k < 6) ? ~b : b, 0);
         tests++; if (obs0 !== exp0()) begin fails++; $display("FAIL win_bound dut0 step %0d: got %h want %h", k, obs0, exp0()); end
      end
      tests++; if (bus0.locked !== 1'b1) begin fails++; $display("FAIL win_bound_locked: got %b want 1", bus0.locked); end
      tests++; if (bus0.err_count !== (CNT_EN ? 16'd6 : 16'd0)) begin fails++; $display("FAIL win_bound_count: got %0d want %0d", bus0.err_count, CNT_EN ? 6 : 0); end
      $display("[TB] window_boundary: 3+3 errors across a block edge");
   endtask

   task automatic test_stuck_high();
      int ever = 0;
      do_reset();
      for (int k = 1; k <= 1000; k++) begin
         cycle(1, 1'b1, 0);
         tests++; if (obs0 !== exp0()) begin fails++; $display("FAIL stuck dut0 bit %0d: got %h want %h", k, obs0, exp0()); end
         if (bus0.locked || bus1.locked) ever++;
      end
      tests++; if (ever !== 0) begin fails++; $display("FAIL stuck_lock: got %0d locked cycles want 0", ever); end
      $display("[TB] stuck_high: 1000 ones applied");
   endtask

   task automatic test_stall();
      int vbits = 0, lock_at = 0;
      bit b;
      do_reset();
      for (int k = 0; k < 200; k++) begin
         if (k % 2 == 0) begin gen(b); cycle(1, b, 0); vbits++; end
         else cycle(0, 1'($urandom), 0);
         tests++; if (obs0 !== exp0()) begin fails++; $display("FAIL stall dut0 cyc %0d: got %h want %h", k, obs0, exp0()); end
         tests++; if (obs1 !== exp1()) begin fails++; $display("FAIL stall dut1 cyc %0d: got %h want %h", k, obs1, exp1()); end
         if (bus0.locked && lock_at == 0) lock_at = vbits;
      end
      tests++; if (lock_at !== N + LOCK_MATCH) begin fails++; $display("FAIL stall_latency: got %0d want %0d", lock_at, N + LOCK_MATCH); end
      $display("[TB] stall: locked after %0d valid bits", lock_at);
   endtask

   task automatic test_saturation();
      bit b;
      gen(b); cycle(1, b, 1);
      for (int k = 0; k < 200; k++) begin
         gen(b); cycle(1, (k % 10 == 0) ? ~b : b, 0);
         tests++; if (obs1 !== exp1()) begin fails++; $display("FAIL sat dut1 bit %0d: got %h want %h", k, obs1, exp1()); end
         tests++; if (obs0 !== exp0()) begin fails++; $display("FAIL sat dut0 bit %0d: got %h want %h", k, obs0, exp0()); end
      end
      tests++; if (bus1.err_count !== (CNT_EN ? 4'd15 : 4'd0)) begin fails++; $display("FAIL sat_hold: got %0d want %0d", bus1.err_count, CNT_EN ? 15 : 0); end
      gen(b); cycle(1, ~b, 1);
      tests++; if (bus1.err_count !== 4'd0 || bus1.bit_err !== 1'b1) begin fails++; $display("FAIL clear_on_err: count=%0d bit_err=%b want 0/1", bus1.err_count, bus1.bit_err); end
      $display("[TB] saturation: 20 errors into 4-bit counter");
   endtask

   task automatic test_random();
      bit b, v, e, c;
      for (int k = 0; k < 3000; k++) begin
         v = ($urandom_range(0, 3) != 0);
         e = ($urandom_range(0, 63) == 0);
         c = ($urandom_range(0, 199) == 0);
         if (v) begin gen(b); cycle(1, b ^ e, c); end
         else cycle(0, 1'($urandom), c);
         tests++; if (obs0 !== exp0()) begin fails++; $display("FAIL random dut0 cyc %0d: got %h want %h", k, obs0, exp0()); end
         tests++; if (obs1 !== exp1()) begin fails++; $display("FAIL random dut1 cyc %0d: got %h want %h", k, obs1, exp1()); end
      end
      $display("[TB] random: 3000 cycles compared");
   endtask

   task automatic test_reset_mid();
      bit b;
      for (int k = 0; k < 64; k++) begin gen(b); cycle(1, (k == 60) ? ~b : b, 0); end
      tests++; if (obs0 !== exp0() || bus0.locked !== 1'b1) begin fails++; $display("FAIL pre_reset: got %h want %h locked", obs0, exp0()); end
      #3 reset = 1;
      #1;
      tests++; if (obs0 !== 18'd0) begin fails++; $display("FAIL async_reset dut0: got %h want 0", obs0); end
      tests++; if (obs1 !== 6'd0)  begin fails++; $display("FAIL async_reset dut1: got %h want 0", obs1); end
      do_reset();
      $display("[TB] reset_mid: asynchronous clear checked");
   endtask

   initial begin
      model_reset();
      test_reset();
      test_clean_lock();
      test_single_error();
      test_loss();
      test_window_boundary();
      test_stuck_high();
      test_stall();
      test_saturation();
      test_random();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
